// File: rtl/hv_sync_generator_pkg.sv
// hv_sync_generator_pkg: shared 256x240 raster timing constants for the display path.
package hv_sync_generator_pkg;

    localparam int H_DISPLAY = 256;
    localparam int H_BACK    = 23;
    localparam int H_FRONT   = 7;
    localparam int H_SYNC    = 23;
    localparam int V_DISPLAY = 240;
    localparam int V_TOP     = 5;
    localparam int V_BOTTOM  = 14;
    localparam int V_SYNC    = 3;

    localparam int H_MAX        = H_DISPLAY + H_BACK + H_FRONT + H_SYNC - 1;
    localparam int V_MAX        = V_DISPLAY + V_TOP + V_BOTTOM + V_SYNC - 1;
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

endpackage

// File: rtl/hv_sync_generator.sv
// hv_sync_generator: free-running pixel/line counters with registered H/V sync and active-video flag.
module hv_sync_generator
    import hv_sync_generator_pkg::*;
#(
    parameter int P_H_DISPLAY = H_DISPLAY,
    parameter int P_H_BACK    = H_BACK,
    parameter int P_H_FRONT   = H_FRONT,
    parameter int P_H_SYNC    = H_SYNC,
    parameter int P_V_DISPLAY = V_DISPLAY,
    parameter int P_V_TOP     = V_TOP,
    parameter int P_V_BOTTOM  = V_BOTTOM,
    parameter int P_V_SYNC    = V_SYNC
) (
    input  logic       clk,
    input  logic       reset,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [8:0] hpos,
    output logic [8:0] vpos
);

    localparam logic [8:0] L_H_MAX = 9'(P_H_DISPLAY + P_H_BACK + P_H_FRONT + P_H_SYNC - 1);
    localparam logic [8:0] L_V_MAX = 9'(P_V_DISPLAY + P_V_TOP + P_V_BOTTOM + P_V_SYNC - 1);
    localparam logic [8:0] L_HS_B  = 9'(P_H_DISPLAY + P_H_FRONT);
    localparam logic [8:0] L_HS_E  = 9'(P_H_DISPLAY + P_H_FRONT + P_H_SYNC - 1);
    localparam logic [8:0] L_VS_B  = 9'(P_V_DISPLAY + P_V_BOTTOM);
    localparam logic [8:0] L_VS_E  = 9'(P_V_DISPLAY + P_V_BOTTOM + P_V_SYNC - 1);
    localparam logic [8:0] L_H_VIS = 9'(P_H_DISPLAY);
    localparam logic [8:0] L_V_VIS = 9'(P_V_DISPLAY);

    logic [8:0] r_hpos;
    logic [8:0] r_vpos;
    logic       r_hsync;
    logic       r_vsync;
    logic       w_line_end;
    logic       w_frame_end;

    assign w_line_end  = (r_hpos == L_H_MAX);
    assign w_frame_end = w_line_end && (r_vpos == L_V_MAX);

    // Sync flags are decoded from the pre-increment counters, so they lag by one clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hpos  <= '0;
            r_vpos  <= '0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_hpos  <= w_line_end ? '0 : r_hpos + 9'd1;
            r_vpos  <= w_frame_end ? '0 : (w_line_end ? r_vpos + 9'd1 : r_vpos);
            r_hsync <= (r_hpos >= L_HS_B) && (r_hpos <= L_HS_E);
            r_vsync <= (r_vpos >= L_VS_B) && (r_vpos <= L_VS_E);
        end
    end

    assign hpos       = r_hpos;
    assign vpos       = r_vpos;
    assign hsync      = r_hsync;
    assign vsync      = r_vsync;
    assign display_on = (r_hpos < L_H_VIS) && (r_vpos < L_V_VIS);

endmodule

// File: tb/tb_hv_sync_generator.sv
// tb_hv_sync_generator: table vectors plus random async resets checked against an arithmetic raster model.
module tb_hv_sync_generator;

    localparam int H_TOT = 309;
    localparam int V_TOT = 262;
    localparam int FRAME = H_TOT * V_TOT;

    typedef struct {
        int         n;
        logic [8:0] h;
        logic [8:0] v;
        logic       hs;
        logic       vs;
        logic       de;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       hsync;
    logic       vsync;
    logic       display_on;
    logic [8:0] hpos;
    logic [8:0] vpos;

    int   n = 0;
    int   vecs = 0;
    int   errs = 0;
    vec_t tbl[14];

    hv_sync_generator dut (
        .clk(clk),
        .reset(reset),
        .hsync(hsync),
        .vsync(vsync),
        .display_on(display_on),
        .hpos(hpos),
        .vpos(vpos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [8:0] h, input logic [8:0] v,
                       input logic hs, input logic vs, input logic de);
        vecs++;
        if (hpos !== h || vpos !== v || hsync !== hs || vsync !== vs || display_on !== de) begin
            errs++;
            $display("FAIL %s n=%0d: got h=%0d v=%0d hs=%b vs=%b de=%b, want h=%0d v=%0d hs=%b vs=%b de=%b",
                     nm, n, hpos, vpos, hsync, vsync, display_on, h, v, hs, vs, de);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int want);
        vecs++;
        if (got != want) begin
            errs++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // n = rising edges since reset release; position is pure modular arithmetic on n.
    task automatic model_check(input string nm);
        int         p;
        logic [8:0] h;
        logic [8:0] v;
        logic       hs;
        logic       vs;
        h  = 9'(n % H_TOT);
        v  = 9'((n / H_TOT) % V_TOT);
        hs = 1'b0;
        vs = 1'b0;
        if (n > 0) begin
            p  = n - 1;
            hs = (p % H_TOT) >= 263 && (p % H_TOT) <= 285;
            vs = ((p / H_TOT) % V_TOT) >= 254 && ((p / H_TOT) % V_TOT) <= 256;
        end
        chk(nm, h, v, hs, vs, (h < 256) && (v < 240));
    endtask

    task automatic step();
        @(posedge clk);
        if (reset) n++;
        @(negedge clk);
    endtask

    task automatic async_reset(input string nm, input int dly, input int hold);
        @(posedge clk);
        #(dly);
        reset = 1'b0;
        n = 0;
        #1;
        chk(nm, 9'd0, 9'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < hold; i++) begin
            step();
            chk({nm, "_hold"}, 9'd0, 9'd0, 1'b0, 1'b0, 1'b1);
        end
        reset = 1'b1;
    endtask

    initial begin
        int ti;
        int hs_rise;
        int hs_fall;
        int vs_rise;
        int vs_fall;
        logic hs_q;
        logic vs_q;
        tbl[0]  = '{256,   9'd256, 9'd0,   1'b0, 1'b0, 1'b0};
        tbl[1]  = '{263,   9'd263, 9'd0,   1'b0, 1'b0, 1'b0};
        tbl[2]  = '{264,   9'd264, 9'd0,   1'b1, 1'b0, 1'b0};
        tbl[3]  = '{286,   9'd286, 9'd0,   1'b1, 1'b0, 1'b0};
        tbl[4]  = '{287,   9'd287, 9'd0,   1'b0, 1'b0, 1'b0};
        tbl[5]  = '{308,   9'd308, 9'd0,   1'b0, 1'b0, 1'b0};
        tbl[6]  = '{309,   9'd0,   9'd1,   1'b0, 1'b0, 1'b1};
        tbl[7]  = '{74106, 9'd255, 9'd239, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{74160, 9'd0,   9'd240, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{78486, 9'd0,   9'd254, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{78487, 9'd1,   9'd254, 1'b0, 1'b1, 1'b0};
        tbl[11] = '{79413, 9'd0,   9'd257, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{80957, 9'd308, 9'd261, 1'b0, 1'b0, 1'b0};
        tbl[13] = '{80958, 9'd0,   9'd0,   1'b0, 1'b0, 1'b1};

        // Power-on reset held for 10 clocks.
        #1;
        chk("reset_async", 9'd0, 9'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("reset_hold", 9'd0, 9'd0, 1'b0, 1'b0, 1'b1);
        end
        reset = 1'b1;

        // Mid-frame asynchronous reset at (100,5).
        while (n < 5 * H_TOT + 100) begin
            step();
            model_check("pre_mid");
        end
        chk("at_100_5", 9'd100, 9'd5, 1'b0, 1'b0, 1'b1);
        async_reset("mid_reset", 2, 10);

        // Full frame: per-cycle model, hand table, and sync edge spacing.
        ti      = 0;
        hs_rise = -1;
        hs_fall = -1;
        vs_rise = -1;
        vs_fall = -1;
        hs_q    = 1'b0;
        vs_q    = 1'b0;
        while (n < FRAME + 2) begin
            step();
            model_check("frame");
            if (ti < 14 && n == tbl[ti].n) begin
                chk($sformatf("tbl%0d", ti), tbl[ti].h, tbl[ti].v, tbl[ti].hs, tbl[ti].vs, tbl[ti].de);
                ti++;
            end
            if (hsync && !hs_q) begin
                if (hs_rise >= 0) chk_int("hs_period", n - hs_rise, H_TOT);
                hs_rise = n;
            end
            if (!hsync && hs_q && hs_fall < 0) begin
                hs_fall = n;
                chk_int("hs_width", hs_fall - hs_rise, 23);
            end
            if (vsync && !vs_q) vs_rise = n;
            if (!vsync && vs_q) vs_fall = n;
            hs_q = hsync;
            vs_q = vsync;
        end
        chk_int("tbl_done", ti, 14);
        chk_int("vs_rise", vs_rise, 254 * H_TOT + 1);
        chk_int("vs_width", vs_fall - vs_rise, 3 * H_TOT);

        // Random run lengths with random asynchronous resets.
        for (int k = 0; k < 6; k++) begin
            int len;
            len = int'($urandom_range(50, 1500));
            for (int i = 0; i < len; i++) begin
                step();
                model_check("rand");
            end
            async_reset("rand_reset", int'($urandom_range(1, 3)), int'($urandom_range(1, 5)));
        end
        for (int i = 0; i < 400; i++) begin
            step();
            model_check("rand_tail");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
